// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: length codes, input FSM encoding and error bit positions
// for the FFT frame controller (PAD exists only with FFT_CTRL_ZERO_PAD_EN).
package fft_ctrl_pkg;

    localparam logic [3:0] CFG_MAX = 4'd13;
    localparam int LEN_W = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef FFT_CTRL_ZERO_PAD_EN
    localparam logic [1:0] ST_PAD  = 2'd2;
`endif
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam int ERR_CFG    = 0;
    localparam int ERR_LEN    = 1;
    localparam int ERR_UNDER  = 2;
    localparam int ERR_ORPHAN = 3;

    // Only meaningful for codes up to CFG_MAX.
    function automatic logic [LEN_W-1:0] cfg2len(input logic [3:0] code);
        return 15'd2 << code;
    endfunction

endpackage

// File: rtl/fft_cfg_fifo.sv
// fft_cfg_fifo: small synchronous FIFO of 4-bit length codes, with
// same-cycle push and pop allowed even when full.
module fft_cfg_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [3:0] din,
    input  logic       pop,
    output logic [3:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames a sample stream into gap-free FFT frames and
// re-frames pipeline output; FFT_CTRL_ZERO_PAD_EN enables early-end padding.
module fft_frame_ctrl #(
    parameter int DATA_W    = 32,
    parameter int GAP_CYC   = 2,
    parameter int CFG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_real,
    input  logic [DATA_W-1:0] s_img,
    input  logic              s_last,
    input  logic [3:0]        s_cfg,
    output logic              fft_start,
    output logic              fft_over,
    output logic [DATA_W-1:0] fft_real,
    output logic [DATA_W-1:0] fft_img,
    input  logic [DATA_W-1:0] pipe_real,
    input  logic [DATA_W-1:0] pipe_img,
    input  logic              pipe_first,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_real,
    output logic [DATA_W-1:0] m_img,
    output logic              m_first,
    output logic              m_last,
    output logic [3:0]        err
);

    import fft_ctrl_pkg::*;

    logic [1:0]        st_q, st_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d, ocnt_q, ocnt_d;
    logic [3:0]        gap_q, gap_d;
    logic              fft_start_q, fft_start_d, fft_over_q, fft_over_d;
    logic [DATA_W-1:0] fft_real_q, fft_real_d, fft_img_q, fft_img_d;
    logic              m_valid_q, m_valid_d, m_first_q, m_first_d;
    logic              m_last_q, m_last_d;
    logic [DATA_W-1:0] m_real_q, m_real_d, m_img_q, m_img_d;
    logic [3:0]        err_q, err_d, in_err;
    logic              orphan;
    logic              push, pop, full, empty;
    logic [3:0]        pop_code;
    logic              last_idx, beat_last;
    logic [1:0]        st_after;

    assign st_after = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

    always_comb begin
        st_d        = st_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        fft_start_d = 1'b0;
        fft_over_d  = 1'b0;
        fft_real_d  = '0;
        fft_img_d   = '0;
        in_err      = '0;
        push        = 1'b0;
        s_ready     = 1'b0;
        last_idx    = (cnt_q == len_q - 15'd1);
        beat_last   = s_valid && s_last;
        unique case (st_q)
            ST_IDLE: begin
                s_ready = !full;
                if (s_valid && !full) begin
                    if (s_cfg <= CFG_MAX) begin
                        len_d       = cfg2len(s_cfg);
                        cnt_d       = 15'd1;
                        push        = 1'b1;
                        fft_start_d = 1'b1;
                        fft_real_d  = s_real;
                        fft_img_d   = s_img;
                        st_d        = ST_RUN;
`ifdef FFT_CTRL_ZERO_PAD_EN
                        if (s_last) st_d = ST_PAD;
`else
                        in_err[ERR_LEN] = s_last;
`endif
                    end else begin
                        in_err[ERR_CFG] = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                s_ready    = 1'b1;
                cnt_d      = cnt_q + 15'd1;
                fft_over_d = last_idx;
                // The pipeline cannot stall, so a missing beat becomes zero.
                if (s_valid) begin
                    fft_real_d = s_real;
                    fft_img_d  = s_img;
                end else begin
                    in_err[ERR_UNDER] = 1'b1;
                end
`ifdef FFT_CTRL_ZERO_PAD_EN
                if (beat_last && !last_idx) st_d = ST_PAD;
`else
                in_err[ERR_LEN] = (beat_last != last_idx);
`endif
                if (last_idx) begin
                    st_d  = st_after;
                    gap_d = '0;
                end
            end
`ifdef FFT_CTRL_ZERO_PAD_EN
            ST_PAD: begin
                cnt_d      = cnt_q + 15'd1;
                fft_over_d = last_idx;
                if (last_idx) begin
                    st_d  = st_after;
                    gap_d = '0;
                end
            end
`endif
            ST_GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == 4'(GAP_CYC)) begin
                    st_d  = ST_IDLE;
                    gap_d = '0;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // ocnt holds the output beats still owed after the current one.
    always_comb begin
        pop       = pipe_first && !empty;
        orphan    = pipe_first && (empty || (ocnt_q != '0));
        ocnt_d    = ocnt_q;
        m_valid_d = 1'b0;
        m_first_d = 1'b0;
        m_last_d  = 1'b0;
        m_real_d  = '0;
        m_img_d   = '0;
        if (pop) begin
            m_valid_d = 1'b1;
            m_first_d = 1'b1;
            ocnt_d    = cfg2len(pop_code) - 15'd1;
        end else if (ocnt_q != '0) begin
            m_valid_d = 1'b1;
            m_last_d  = (ocnt_q == 15'd1);
            ocnt_d    = ocnt_q - 15'd1;
        end
        if (m_valid_d) begin
            m_real_d = pipe_real;
            m_img_d  = pipe_img;
        end
        err_d             = in_err;
        err_d[ERR_ORPHAN] = orphan;
    end

    fft_cfg_fifo #(
        .DEPTH (CFG_DEPTH)
    ) u_cfg_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (s_cfg),
        .pop   (pop),
        .dout  (pop_code),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            ocnt_q      <= '0;
            fft_start_q <= 1'b0;
            fft_over_q  <= 1'b0;
            fft_real_q  <= '0;
            fft_img_q   <= '0;
            m_valid_q   <= 1'b0;
            m_first_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_real_q    <= '0;
            m_img_q     <= '0;
            err_q       <= '0;
        end else begin
            st_q        <= st_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ocnt_q      <= ocnt_d;
            fft_start_q <= fft_start_d;
            fft_over_q  <= fft_over_d;
            fft_real_q  <= fft_real_d;
            fft_img_q   <= fft_img_d;
            m_valid_q   <= m_valid_d;
            m_first_q   <= m_first_d;
            m_last_q    <= m_last_d;
            m_real_q    <= m_real_d;
            m_img_q     <= m_img_d;
            err_q       <= err_d;
        end
    end

    assign fft_start = fft_start_q;
    assign fft_over  = fft_over_q;
    assign fft_real  = fft_real_q;
    assign fft_img   = fft_img_q;
    assign m_valid   = m_valid_q;
    assign m_first   = m_first_q;
    assign m_last    = m_last_q;
    assign m_real    = m_real_q;
    assign m_img     = m_img_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: frame table, corner sequences and random frames checked
// against a frame-level model; honours FFT_CTRL_ZERO_PAD_EN.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;

    localparam int DATA_W    = 32;
    localparam int GAP_CYC   = 2;
    localparam int CFG_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_real = '0;
    logic [DATA_W-1:0] s_img = '0;
    logic              s_last = 1'b0;
    logic [3:0]        s_cfg = '0;
    logic              fft_start, fft_over;
    logic [DATA_W-1:0] fft_real, fft_img;
    logic [DATA_W-1:0] pipe_real = '0;
    logic [DATA_W-1:0] pipe_img = '0;
    logic              pipe_first = 1'b0;
    logic              m_valid, m_first, m_last;
    logic [DATA_W-1:0] m_real, m_img;
    logic [3:0]        err;

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .DATA_W    (DATA_W),
        .GAP_CYC   (GAP_CYC),
        .CFG_DEPTH (CFG_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_real     (s_real),
        .s_img      (s_img),
        .s_last     (s_last),
        .s_cfg      (s_cfg),
        .fft_start  (fft_start),
        .fft_over   (fft_over),
        .fft_real   (fft_real),
        .fft_img    (fft_img),
        .pipe_real  (pipe_real),
        .pipe_img   (pipe_img),
        .pipe_first (pipe_first),
        .m_valid    (m_valid),
        .m_real     (m_real),
        .m_img      (m_img),
        .m_first    (m_first),
        .m_last     (m_last),
        .err        (err)
    );

    typedef struct {
        logic [3:0] cfg;
        int         drop;
        int         lastix;
        int         exp_len;
    } vec_t;

    vec_t       vecs [8];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] cfgq [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // One input frame; len is the expected pipeline length (0 = dropped).
    task automatic run_frame(input logic [3:0] cfg, input int drop,
                             input int lastix, input int len);
        int nb;
        bit pad, v, lst, und, lerr;
        logic [DATA_W-1:0] er, ei;
        nb  = (len == 0) ? 1 : len;
        pad = 1'b0;
        for (int idx = 0; idx < nb; idx++) begin
            v       = (idx == 0) || (idx != drop);
            lst     = (idx == lastix);
            s_valid = pad ? 1'b1 : v;
            s_cfg   = (idx == 0) ? cfg : 4'd0;
            s_real  = $urandom;
            s_img   = $urandom;
            s_last  = lst;
            chk("s_ready", s_ready, !pad);
            er  = (pad || !v) ? '0 : s_real;
            ei  = (pad || !v) ? '0 : s_img;
            und = !pad && !v;
`ifdef FFT_CTRL_ZERO_PAD_EN
            lerr = 1'b0;
`else
            lerr = (v && lst) != (idx == len - 1);
`endif
            @(posedge clk);
            #1;
            if (len == 0) begin
                chk("cfg_drop_start", fft_start, 0);
                chk("cfg_err", err[2:0], 3'b001);
                s_valid = 1'b0;
                return;
            end
            if (idx == 0) cfgq.push_back(cfg);
            chk("fft_start", fft_start, idx == 0);
            chk("fft_over", fft_over, idx == len - 1);
            chk("fft_real", fft_real, er);
            chk("fft_img", fft_img, ei);
            chk("in_err", err[2:0], {und, lerr, 1'b0});
`ifdef FFT_CTRL_ZERO_PAD_EN
            if (!pad && v && lst && idx < len - 1) pad = 1'b1;
`endif
        end
        s_valid = 1'b1;
        s_cfg   = 4'd0;
        s_last  = 1'b0;
        for (int g = 0; g < ((GAP_CYC == 0) ? 0 : GAP_CYC + 1); g++) begin
            chk("gap_ready", s_ready, 0);
            @(posedge clk);
            #1;
            chk("gap_start", fft_start, 0);
        end
        s_valid = 1'b0;
        chk("post_ready", s_ready, cfgq.size() < CFG_DEPTH);
    endtask

    // Pipeline output frame; ncyc=0 runs the full length.
    task automatic run_out(input int ncyc, input bit orph);
        int len, n;
        logic [3:0] c;
        logic [DATA_W-1:0] pr, pi;
        pipe_first = 1'b1;
        if (cfgq.size() == 0) begin
            @(posedge clk);
            #1;
            pipe_first = 1'b0;
            chk("orph_empty_valid", m_valid, 0);
            chk("orph_empty_err", err[3], 1);
            return;
        end
        c   = cfgq.pop_front();
        len = 2 << c;
        n   = (ncyc == 0) ? len : ncyc;
        for (int k = 0; k < n; k++) begin
            pr        = $urandom;
            pi        = $urandom;
            pipe_real = pr;
            pipe_img  = pi;
            @(posedge clk);
            #1;
            pipe_first = 1'b0;
            chk("m_valid", m_valid, 1);
            chk("m_first", m_first, k == 0);
            chk("m_last", m_last, k == len - 1);
            chk("m_real", m_real, pr);
            chk("m_img", m_img, pi);
            chk("orphan", err[3], (k == 0) && orph);
        end
        if (n == len) begin
            @(posedge clk);
            #1;
            chk("m_idle", m_valid, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd2, -1, 7, 8};
        vecs[1] = '{4'd1, 2, 3, 4};
        vecs[2] = '{4'd3, -1, 4, 16};
        vecs[3] = '{4'd14, -1, 0, 0};
        vecs[4] = '{4'd0, -1, 1, 2};
        vecs[5] = '{4'd15, -1, 0, 0};
        vecs[6] = '{4'd0, -1, -1, 2};
        vecs[7] = '{4'd1, 1, 3, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {fft_start, fft_over, m_valid, m_first, m_last, err}, 0);
        chk("rst_data", fft_real | fft_img | m_real | m_img, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", s_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].cfg, vecs[i].drop, vecs[i].lastix,
                      vecs[i].exp_len);
            if (vecs[i].exp_len != 0) run_out(0, 0);
        end

        run_out(0, 0);

        run_frame(4'd1, -1, 3, 4);
        for (int i = 0; i < 3; i++) run_frame(4'd0, -1, 1, 2);
        s_valid = 1'b1;
        s_cfg   = 4'd0;
        s_last  = 1'b0;
        repeat (3) begin
            chk("full_ready", s_ready, 0);
            @(posedge clk);
            #1;
            chk("full_start", fft_start, 0);
        end
        fork
            run_out(0, 0);
            begin
                @(posedge clk);
                #1;
                chk("pop_cycle_start", fft_start, 0);
                run_frame(4'd0, -1, 1, 2);
            end
        join

        run_out(1, 0);
        run_out(0, 1);
        run_out(0, 0);
        run_out(0, 0);
        run_out(0, 0);

        s_valid = 1'b1;
        s_cfg   = 4'd3;
        s_last  = 1'b0;
        s_real  = $urandom;
        @(posedge clk);
        #1;
        chk("mid_rst_start", fft_start, 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {fft_start, fft_over, m_valid, err}, 0);
        chk("mid_rst_data", fft_real | fft_img, 0);
        s_valid = 1'b0;
        cfgq.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", s_ready, 1);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            chk("mid_rst_no_over", fft_over, 0);
        end

        for (int f = 0; f < 24; f++) begin
            logic [3:0] cfg;
            int el, drop, lastix;
            if ($urandom_range(0, 9) == 0) cfg = 4'(14 + $urandom_range(0, 1));
            else cfg = 4'($urandom_range(0, 4));
            el     = (cfg <= 4'd13) ? (2 << cfg) : 0;
            drop   = -1;
            lastix = 0;
            if (el != 0) begin
                if ($urandom_range(0, 1) == 1) drop = $urandom_range(1, el - 1);
                if ($urandom_range(0, 3) == 0) lastix = $urandom_range(0, el - 1);
                else lastix = el - 1;
            end
            run_frame(cfg, drop, lastix, el);
            if (cfgq.size() == CFG_DEPTH || $urandom_range(0, 1) == 1)
                run_out(0, 0);
        end
        while (cfgq.size() != 0) run_out(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer in front of and behind the cascaded radix-2 FFT pipeline (`fft_top`). It accepts a valid/ready sample stream and latches a per-frame length code. It drives the pipeline's `start`/`over`/data inputs as one gap-free frame of N = 2^(code+1) samples. On the output side it re-frames the pipeline's first-sample marker into `m_valid`/`m_first`/`m_last` framing for N samples.

## Interface
Parameters:
- `DATA_W`, 32: width of each real/imag sample.
- `GAP_CYC`, 2: minimum idle cycles between the last sample of one frame and the next frame's first sample (0..15).
- `CFG_DEPTH`, 4: number of frames that may be in flight in the pipeline (length-code FIFO depth, power of 2).

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: **active-low, asynchronous** reset.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: input ready.
- `s_real` in DATA_W: input real part.
- `s_img` in DATA_W: input imaginary part.
- `s_last` in 1: producer's end-of-frame marker.
- `s_cfg` in 4: length code, sampled on a frame's first beat.
- `fft_start` out 1: one-cycle pulse aligned with sample 0 to the pipeline.
- `fft_over` out 1: one-cycle pulse aligned with sample N-1 to the pipeline.
- `fft_real` out DATA_W: sample real part to the pipeline.
- `fft_img` out DATA_W: sample imaginary part to the pipeline.
- `pipe_real` in DATA_W: pipeline output real part.
- `pipe_img` in DATA_W: pipeline output imaginary part.
- `pipe_first` in 1: pipeline's out_first pulse.
- `m_valid` out 1: output sample valid.
- `m_real` out DATA_W: output real part.
- `m_img` out DATA_W: output imaginary part.
- `m_first` out 1: first output sample of a frame.
- `m_last` out 1: last output sample of a frame.
- `err` out 4: one-cycle pulses, {orphan, underrun, len_err, cfg_err}.

## Operation
- Input FSM states: IDLE, RUN, PAD, GAP.
- **IDLE**
  - `s_ready` = !cfg_fifo_full.
  - On an accepted beat with `s_cfg` ≤ 13: latch len = 2^(s_cfg+1) and push s_cfg to the FIFO. Emit the sample with `fft_start`=1 and set cnt=1. Go to RUN, or to GAP if len would be 1 (not reachable; minimum length is 2).
  - On an accepted beat with `s_cfg` 14 or 15: beat consumed and dropped, `cfg_err` pulse, stay in IDLE.
- **RUN**
  - `s_ready`=1.
  - The pipeline must receive one sample every cycle, so every RUN cycle emits a sample and increments cnt.
  - If `s_valid`=0, a zero sample is emitted and `underrun` pulses.
  - When cnt reaches len-1, the emitted sample carries `fft_over`=1, then go to GAP.
  - `s_last` on a beat other than index len-1: see Configuration.
- **PAD**: `s_ready`=0. Emit zeros each cycle until index len-1, which carries `fft_over`. Then go to GAP.
- **GAP**: `s_ready`=0. Hold for GAP_CYC cycles, then go to IDLE. If GAP_CYC=0, go directly to IDLE.
- Output side, on `pipe_first`:
  - Pop the FIFO and load ocnt = len(code).
  - Assert `m_valid` for that many consecutive cycles. `m_first` is set on the first of them and `m_last` on the last.
- Output boundary cases:
  - `pipe_first` with the FIFO empty: `orphan` pulse, pulse ignored.
  - `pipe_first` while ocnt≠0: truncate the current frame (no `m_last`), start the new frame, and pulse `orphan`.
- Simultaneous FIFO push and pop in one cycle is legal, including when the FIFO is full.

## Timing
- `fft_*` and `m_*` are registered: 1-cycle latency from the accepted beat or from `pipe_first`/`pipe_*`.
- Frame length at the pipeline is exactly len cycles, with `fft_start` and `fft_over` 1 cycle wide.
- Length-2 frame: `fft_start` and `fft_over` fall on consecutive cycles.
- Reset values:
  - All outputs 0.
  - FSM in IDLE, FIFO empty, counters 0.
  - `s_ready` is 1 after reset deasserts.
- Reset asserted mid-frame: everything clears immediately and no `fft_over` is issued. The pipeline shares the same reset.

## Configuration
- `FFT_CTRL_ZERO_PAD_EN` defined: `s_last` on a beat with index < len-1 ends input early and enters PAD; `len_err` is not pulsed.
- Undefined:
  - `s_last` is ignored for framing. The frame always consumes len beats.
  - `len_err` pulses when `s_last` arrives early, or when it is absent on beat len-1.
  - The PAD state does not exist.

## Structure
- `fft_ctrl_pkg`:
  - length-code constants (CFG_MAX=13);
  - input FSM state enum;
  - `cfg2len` function (4-bit code to 15-bit length);
  - err bit index constants.
- Sub-module `fft_cfg_fifo`: synchronous FIFO (width 4, depth CFG_DEPTH) with full/empty flags and same-cycle push/pop.

## Test plan
- s_cfg=2, 8 beats back-to-back, GAP_CYC=2:
  - `fft_start` on sample 0 and `fft_over` on sample 7, 1 cycle after acceptance.
  - `s_ready` is low for 3 cycles after the last beat (1 cycle leaving RUN plus 2 GAP).
- s_cfg=1, `s_valid` dropped on beat 2: zero emitted at index 2, `underrun`=1 for 1 cycle, `fft_over` still at index 3.
- With the macro defined, s_cfg=3 and `s_last` on beat 4: indices 5..15 are zero and `fft_over` is at index 15. Without the macro: `len_err` pulses and the frame consumes 16 beats.
- s_cfg=14: beat dropped, `cfg_err` pulse, no `fft_start`. A following s_cfg=0 frame proceeds normally.
- Four frames started with no `pipe_first`: `s_ready`=0 in IDLE. One `pipe_first` pops the FIFO, and the next frame starts the following cycle.
- `pipe_first` with the FIFO empty: `orphan` pulse and `m_valid` stays 0. `pipe_first` for code 1 gives `m_valid` for 4 cycles, with `m_first` on cycle 1 and `m_last` on cycle 4.
